// File: rtl/fproc_pkg.sv
// fproc_pkg
//   Shared definitions for the function-processor interface slice:
//   FSM state encodings, default field widths and the fill bit used to
//   build the all-ones result word returned on a timeout.
package fproc_pkg;

    // FSM state encodings (fixed values, legacy-compatible)
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] REQ       = 2'd1;
    localparam logic [1:0] WAIT_RESP = 2'd2;
    localparam logic [1:0] DONE      = 2'd3;

    // Default widths
    localparam int unsigned FPROC_DEFAULT_ID_WIDTH = 8;
    localparam int unsigned FPROC_DEFAULT_DATA_WIDTH = 32;

    // Result word on timeout is this bit replicated across DATA_WIDTH
    localparam logic FPROC_TIMEOUT_FILL = 1'b1;

endpackage

// File: rtl/fproc_timeout_ctr.sv
// fproc_timeout_ctr
//   Cycle counter guarding an outstanding fproc transaction.
//   Ports:
//     clk     core clock
//     reset   asynchronous, active-high reset
//     clear   restart the count from zero (start of a new request)
//     enable  count this cycle (transaction outstanding)
//     expire  high while enabled and the count has reached TIMEOUT_CYCLES-1
module fproc_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign expire = enable && (count == LAST);

endmodule

// File: rtl/fproc_iface.sv
// fproc_iface
//   Bridges the core control FSM and the function processor (fproc).
//   A request strobe from the control FSM starts a req/ack handshake with
//   the fproc; the response word is captured and presented with a level
//   ready flag that is held until the next request.
//   Build option: define FPROC_TIMEOUT_EN to abandon a transaction after
//   TIMEOUT_CYCLES cycles, returning an all-ones word and a sticky timeout.
//   Ports:
//     clk, reset          core clock, asynchronous active-high reset
//     fproc_out_ready     request strobe from control FSM
//     fproc_id_in         function ID, valid with fproc_out_ready
//     fproc_ready         result valid (level)
//     fproc_data          captured result word
//     fproc_req           request to fproc
//     fproc_req_id        latched function ID
//     fproc_ack           fproc accepted the request
//     fproc_resp_valid    fproc response word valid
//     fproc_resp_data     fproc response word
//     busy                transaction outstanding (REQ or WAIT_RESP)
//     protocol_err        sticky protocol error, cleared only by reset
//     timeout             sticky timeout (0 unless FPROC_TIMEOUT_EN)
module fproc_iface
    import fproc_pkg::*;
#(
    parameter int unsigned FPROC_ID_WIDTH = FPROC_DEFAULT_ID_WIDTH,
    parameter int unsigned DATA_WIDTH     = FPROC_DEFAULT_DATA_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      fproc_out_ready,
    input  logic [FPROC_ID_WIDTH-1:0] fproc_id_in,
    output logic                      fproc_ready,
    output logic [DATA_WIDTH-1:0]     fproc_data,
    output logic                      fproc_req,
    output logic [FPROC_ID_WIDTH-1:0] fproc_req_id,
    input  logic                      fproc_ack,
    input  logic                      fproc_resp_valid,
    input  logic [DATA_WIDTH-1:0]     fproc_resp_data,
    output logic                      busy,
    output logic                      protocol_err,
    output logic                      timeout
);

    logic [1:0] state;
    logic       start_req;
    logic       expire;

    // A new request is accepted only when no transaction is outstanding
    assign start_req = fproc_out_ready && ((state == IDLE) || (state == DONE));

`ifdef FPROC_TIMEOUT_EN
    logic timeout_hit;

    fproc_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk    (clk),
        .reset  (reset),
        .clear  (start_req),
        .enable (busy),
        .expire (expire)
    );

    // A response arriving in the expiry cycle takes priority over the timeout
    assign timeout_hit = expire &&
        (((state == REQ) && !(fproc_ack && fproc_resp_valid)) ||
         ((state == WAIT_RESP) && !fproc_resp_valid));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout <= 1'b0;
        end else if (timeout_hit) begin
            timeout <= 1'b1;
        end
    end
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            fproc_req    <= 1'b0;
            fproc_req_id <= '0;
            fproc_ready  <= 1'b0;
            fproc_data   <= '0;
            busy         <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    // No transaction outstanding: any response is stray
                    if (fproc_resp_valid) begin
                        protocol_err <= 1'b1;
                    end
                    if (fproc_out_ready) begin
                        fproc_req_id <= fproc_id_in;
                        fproc_req    <= 1'b1;
                        busy         <= 1'b1;
                        fproc_ready  <= 1'b0;
                        state        <= REQ;
                    end
                end

                REQ: begin
                    if (fproc_out_ready) begin
                        protocol_err <= 1'b1;
                    end
                    if (fproc_ack && fproc_resp_valid) begin
                        fproc_data  <= fproc_resp_data;
                        fproc_req   <= 1'b0;
                        busy        <= 1'b0;
                        fproc_ready <= 1'b1;
                        state       <= DONE;
                    end else begin
                        if (fproc_resp_valid) begin
                            protocol_err <= 1'b1;
                        end
                        if (expire) begin
                            fproc_data  <= {DATA_WIDTH{FPROC_TIMEOUT_FILL}};
                            fproc_req   <= 1'b0;
                            busy        <= 1'b0;
                            fproc_ready <= 1'b1;
                            state       <= DONE;
                        end else if (fproc_ack) begin
                            fproc_req <= 1'b0;
                            state     <= WAIT_RESP;
                        end
                    end
                end

                WAIT_RESP: begin
                    if (fproc_out_ready) begin
                        protocol_err <= 1'b1;
                    end
                    if (fproc_resp_valid) begin
                        fproc_data  <= fproc_resp_data;
                        busy        <= 1'b0;
                        fproc_ready <= 1'b1;
                        state       <= DONE;
                    end else if (expire) begin
                        fproc_data  <= {DATA_WIDTH{FPROC_TIMEOUT_FILL}};
                        busy        <= 1'b0;
                        fproc_ready <= 1'b1;
                        state       <= DONE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fproc_iface.sv
// tb_fproc_iface
//   Directed self-checking bench for fproc_iface. Inputs change 1 time unit
//   after each rising edge; outputs are sampled at the same point.
module tb_fproc_iface;

    logic        clk;
    logic        reset;
    logic        fproc_out_ready;
    logic [7:0]  fproc_id_in;
    logic        fproc_ready;
    logic [31:0] fproc_data;
    logic        fproc_req;
    logic [7:0]  fproc_req_id;
    logic        fproc_ack;
    logic        fproc_resp_valid;
    logic [31:0] fproc_resp_data;
    logic        busy;
    logic        protocol_err;
    logic        timeout;

    int checks;
    int failures;

    fproc_iface #(
        .FPROC_ID_WIDTH (8),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .fproc_out_ready  (fproc_out_ready),
        .fproc_id_in      (fproc_id_in),
        .fproc_ready      (fproc_ready),
        .fproc_data       (fproc_data),
        .fproc_req        (fproc_req),
        .fproc_req_id     (fproc_req_id),
        .fproc_ack        (fproc_ack),
        .fproc_resp_valid (fproc_resp_valid),
        .fproc_resp_data  (fproc_resp_data),
        .busy             (busy),
        .protocol_err     (protocol_err),
        .timeout          (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic rdy, input logic [31:0] dat,
                            input logic rq, input logic [7:0] rid, input logic bsy,
                            input logic err, input logic tmo);
        chk({tag, ".ready"},   64'(fproc_ready),  64'(rdy));
        chk({tag, ".data"},    64'(fproc_data),   64'(dat));
        chk({tag, ".req"},     64'(fproc_req),    64'(rq));
        chk({tag, ".req_id"},  64'(fproc_req_id), 64'(rid));
        chk({tag, ".busy"},    64'(busy),         64'(bsy));
        chk({tag, ".err"},     64'(protocol_err), 64'(err));
        chk({tag, ".timeout"}, 64'(timeout),      64'(tmo));
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        reset            = 1'b1;
        fproc_out_ready  = 1'b0;
        fproc_id_in      = 8'h00;
        fproc_ack        = 1'b0;
        fproc_resp_valid = 1'b0;
        fproc_resp_data  = 32'h0;

        // Reset state
        step();
        step();
        chk_outs("reset", 1'b0, 32'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        step();

        // 1: basic handshake, ack 3 cycles after request, response 5 after ack
        fproc_out_ready = 1'b1;
        fproc_id_in     = 8'h2A;
        step();
        chk_outs("t1_req", 1'b0, 32'h0, 1'b1, 8'h2A, 1'b1, 1'b0, 1'b0);
        fproc_out_ready = 1'b0;
        fproc_id_in     = 8'h77;
        step();
        step();
        chk_outs("t1_req_hold", 1'b0, 32'h0, 1'b1, 8'h2A, 1'b1, 1'b0, 1'b0);
        fproc_ack = 1'b1;
        step();
        chk_outs("t1_wait", 1'b0, 32'h0, 1'b0, 8'h2A, 1'b1, 1'b0, 1'b0);
        fproc_ack = 1'b0;
        step();
        step();
        step();
        step();
        chk_outs("t1_wait_hold", 1'b0, 32'h0, 1'b0, 8'h2A, 1'b1, 1'b0, 1'b0);
        fproc_resp_valid = 1'b1;
        fproc_resp_data  = 32'h1234_5678;
        step();
        chk_outs("t1_done", 1'b1, 32'h1234_5678, 1'b0, 8'h2A, 1'b0, 1'b0, 1'b0);
        fproc_resp_valid = 1'b0;
        fproc_resp_data  = 32'h5555_AAAA;
        step();
        chk_outs("t1_done_hold", 1'b1, 32'h1234_5678, 1'b0, 8'h2A, 1'b0, 1'b0, 1'b0);

        // 3: back-to-back request from DONE; old data held until new capture
        fproc_out_ready = 1'b1;
        fproc_id_in     = 8'h05;
        step();
        chk_outs("t3_req", 1'b0, 32'h1234_5678, 1'b1, 8'h05, 1'b1, 1'b0, 1'b0);
        fproc_out_ready = 1'b0;

        // 2: ack and response together on the first fproc_req cycle
        fproc_ack        = 1'b1;
        fproc_resp_valid = 1'b1;
        fproc_resp_data  = 32'hDEAD_BEEF;
        step();
        chk_outs("t2_done", 1'b1, 32'hDEAD_BEEF, 1'b0, 8'h05, 1'b0, 1'b0, 1'b0);
        fproc_ack        = 1'b0;
        fproc_resp_valid = 1'b0;

        // 4: request strobe during WAIT_RESP is ignored and flagged
        fproc_out_ready = 1'b1;
        fproc_id_in     = 8'h33;
        step();
        fproc_out_ready = 1'b0;
        fproc_ack       = 1'b1;
        step();
        fproc_ack       = 1'b0;
        fproc_out_ready = 1'b1;
        fproc_id_in     = 8'h44;
        step();
        chk_outs("t4_err", 1'b0, 32'hDEAD_BEEF, 1'b0, 8'h33, 1'b1, 1'b1, 1'b0);
        fproc_out_ready  = 1'b0;
        fproc_resp_valid = 1'b1;
        fproc_resp_data  = 32'hA5A5_0F0F;
        step();
        chk_outs("t4_done", 1'b1, 32'hA5A5_0F0F, 1'b0, 8'h33, 1'b0, 1'b1, 1'b0);
        fproc_resp_valid = 1'b0;
        step();
        step();
        chk("t4_err_sticky", 64'(protocol_err), 64'd1);

        // 5: asynchronous reset mid-WAIT_RESP, then a late stray response
        fproc_out_ready = 1'b1;
        fproc_id_in     = 8'h5C;
        step();
        fproc_out_ready = 1'b0;
        fproc_ack       = 1'b1;
        step();
        fproc_ack = 1'b0;
        step();
        chk("t5_busy_before", 64'(busy), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk_outs("t5_async_rst", 1'b0, 32'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step();
        reset = 1'b0;
        step();
        fproc_resp_valid = 1'b1;
        fproc_resp_data  = 32'hBAD0_BAD0;
        step();
        chk_outs("t5_stray", 1'b0, 32'h0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        fproc_resp_valid = 1'b0;

        // Response in the 16th outstanding cycle (expiry cycle when enabled) wins
        fproc_out_ready = 1'b1;
        fproc_id_in     = 8'h70;
        step();
        fproc_out_ready = 1'b0;
        fproc_ack       = 1'b1;
        step();
        fproc_ack = 1'b0;
        repeat (14) step();
        chk_outs("edge_wait", 1'b0, 32'h0, 1'b0, 8'h70, 1'b1, 1'b1, 1'b0);
        fproc_resp_valid = 1'b1;
        fproc_resp_data  = 32'h0BAD_F00D;
        step();
        chk_outs("edge_resp_wins", 1'b1, 32'h0BAD_F00D, 1'b0, 8'h70, 1'b0, 1'b1, 1'b0);
        fproc_resp_valid = 1'b0;

        // 6: never ack
        fproc_out_ready = 1'b1;
        fproc_id_in     = 8'h66;
        step();
        fproc_out_ready = 1'b0;
`ifdef FPROC_TIMEOUT_EN
        repeat (15) step();
        chk_outs("t6_pre_expiry", 1'b0, 32'h0BAD_F00D, 1'b1, 8'h66, 1'b1, 1'b1, 1'b0);
        step();
        chk_outs("t6_timeout", 1'b1, 32'hFFFF_FFFF, 1'b0, 8'h66, 1'b0, 1'b1, 1'b1);
        step();
        chk("t6_timeout_sticky", 64'(timeout), 64'd1);
`else
        repeat (10000) step();
        chk_outs("t6_no_timeout", 1'b0, 32'h0BAD_F00D, 1'b1, 8'h66, 1'b1, 1'b1, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fproc_iface.md
Name: fproc_iface

Overview:
- Sits between the core control FSM and the function processor (fproc).
- Consumes the control FSM's `fproc_out_ready` request and the function ID from the current instruction.
- Runs a req/ack handshake with the fproc, then captures the response word.
- Presents `fproc_ready` plus `fproc_data` back to the control FSM and ALU input mux (fproc ALU input select); `fproc_ready` is held until the next request, so the control FSM's wait state cannot miss it.

Parameters:
- FPROC_ID_WIDTH, 8, width of the function ID field.
- DATA_WIDTH, 32, width of the fproc response / ALU operand.
- TIMEOUT_CYCLES, 1024, timeout limit in cycles; used only when FPROC_TIMEOUT_EN is defined; must be >= 2.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- fproc_out_ready  in  1  request strobe from the control FSM; sampled on every rising edge.
- fproc_id_in  in  FPROC_ID_WIDTH  function ID; valid in the cycle `fproc_out_ready`=1.
- fproc_ready  out  1  result valid to the control FSM; level signal.
- fproc_data  out  DATA_WIDTH  captured result; stable while `fproc_ready`=1.
- fproc_req  out  1  request to the fproc.
- fproc_req_id  out  FPROC_ID_WIDTH  latched function ID.
- fproc_ack  in  1  fproc accepted the request.
- fproc_resp_valid  in  1  response word valid.
- fproc_resp_data  in  DATA_WIDTH  response word.
- busy  out  1  high in REQ or WAIT_RESP.
- protocol_err  out  1  sticky error flag; cleared only by reset.
- timeout  out  1  sticky timeout flag; constant 0 without FPROC_TIMEOUT_EN.

Behaviour:
- Reset (asynchronous, any state, including mid-handshake):
  - state=IDLE.
  - All outputs 0: `fproc_req`, `fproc_req_id`, `fproc_ready`, `fproc_data`, `busy`, `protocol_err`, `timeout`.
  - An in-flight fproc transaction is abandoned; a response arriving after reset is a stray response (see IDLE).
- All outputs are registered.
- IDLE:
  - `fproc_out_ready`=1: latch `fproc_id_in` into `fproc_req_id`, go to REQ.
  - `fproc_resp_valid`=1: ignore the data, set `protocol_err`.
- REQ:
  - `fproc_req`=1, `fproc_req_id` held.
  - `fproc_ack`=1 with `fproc_resp_valid`=0: go to WAIT_RESP, drop `fproc_req` next cycle.
  - `fproc_ack`=1 with `fproc_resp_valid`=1 in the same cycle: capture `fproc_resp_data`, go directly to DONE.
  - `fproc_resp_valid`=1 without `fproc_ack`: ignore, set `protocol_err`.
- WAIT_RESP:
  - `fproc_resp_valid`=1: capture data into `fproc_data`, go to DONE.
- DONE:
  - `fproc_ready`=1, `fproc_data` held.
  - `fproc_out_ready`=1: latch the new ID, clear `fproc_ready` next cycle, go to REQ (back-to-back requests allowed).
  - `fproc_data` keeps the old value until the next capture.
- `fproc_out_ready`=1 in REQ or WAIT_RESP: request ignored, set `protocol_err`, current transaction continues.
- Latency:
  - `fproc_out_ready` sampled at edge N -> `fproc_req`=1 from edge N.
  - `fproc_resp_valid` sampled at edge M -> `fproc_ready`=1 and `fproc_data` valid from edge M.
  - Minimum request-to-ready: 2 cycles (ack and response in the same cycle as the first `fproc_req`).
- Width rules:
  - `fproc_id_in` is taken verbatim; no arithmetic.
  - `fproc_data` is a full DATA_WIDTH copy; no extension or truncation.

Optional Feature:
- Macro: FPROC_TIMEOUT_EN.
- Defined:
  - Cycle counter of width $clog2(TIMEOUT_CYCLES+1); cleared on entry to REQ; counts in REQ and WAIT_RESP.
  - When the count reaches TIMEOUT_CYCLES-1 with no response: go to DONE with `fproc_data` = all ones, set `timeout` (sticky), drop `fproc_req`.
  - A response arriving in the same cycle as expiry wins: data is captured and no timeout is flagged.
  - Later stray responses are handled per the IDLE/DONE rules; in DONE they are ignored and set `protocol_err`.
- Undefined: no counter, the block waits indefinitely, `timeout` tied to 0.

Decomposition:
- Shared package `fproc_pkg`:
  - State encoding localparams: IDLE=0, REQ=1, WAIT_RESP=2, DONE=3.
  - Default FPROC_ID_WIDTH and DATA_WIDTH.
  - Timeout fill constant (all ones).
- Sub-module `fproc_timeout_ctr`:
  - Inputs: clear/enable. Output: expire strobe.
  - Instantiated only under FPROC_TIMEOUT_EN.
- The FSM stays inline in `fproc_iface`.

Test Plan:
1. Basic handshake: pulse `fproc_out_ready` with id=0x2A; ack 3 cycles later; response 0x1234_5678 5 cycles after ack -> `fproc_req_id`=0x2A while `fproc_req`=1; `fproc_ready`=1 and `fproc_data`=0x12345678 the cycle after the response; `busy`=0 after.
2. Same-cycle ack and response (0xDEADBEEF) on the first `fproc_req` cycle -> `fproc_ready` 2 cycles after the request strobe; no WAIT_RESP visit.
3. Back-to-back requests: new `fproc_out_ready` (id=0x05) while in DONE -> `fproc_ready` drops next cycle, `fproc_req`=1 with id 0x05, old data held until the new capture.
4. Protocol errors: `fproc_out_ready` during WAIT_RESP, and `fproc_resp_valid` in IDLE -> `protocol_err`=1 sticky; the original transaction completes with correct data.
5. Reset asserted mid-WAIT_RESP (asynchronously, between edges) -> all outputs 0 immediately; a late response afterwards sets only `protocol_err`.
6. FPROC_TIMEOUT_EN with TIMEOUT_CYCLES=16: never ack -> DONE after 16 cycles in REQ, `fproc_data`=0xFFFFFFFF, `timeout`=1. Without the macro: still in REQ after 10000 cycles, `timeout`=0.
